// File: rtl/wddl_xor2_8_reg_if.sv
// -----------------------------------------------------------------------------
// wddl_xor2_8_reg_if
// Bundles the dual-rail operand and result signals of wddl_xor2_8_reg.
//
// Signals:
//   d0_p_in, d0_n_in  operand 0, true / complement rail      (master -> slave)
//   d1_p_in, d1_n_in  operand 1, true / complement rail      (master -> slave)
//   d_p_out, d_n_out  registered XOR result, true / complement rail
//   eval_out          result word fully evaluated (every bit complementary)
//   pre_out           result word fully precharged (every bit (0,0))
//   err_out           an input bit pair was (1,1) in the sampled cycle
//   err_cnt_out       saturating count of cycles with err_out set
//
// Modports:
//   master  drives operands and observes results (producer / testbench)
//   slave   the registered XOR itself
// -----------------------------------------------------------------------------
interface wddl_xor2_8_reg_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     d0_p_in;
    logic [WIDTH-1:0]     d0_n_in;
    logic [WIDTH-1:0]     d1_p_in;
    logic [WIDTH-1:0]     d1_n_in;
    logic [WIDTH-1:0]     d_p_out;
    logic [WIDTH-1:0]     d_n_out;
    logic                 eval_out;
    logic                 pre_out;
    logic                 err_out;
    logic [ERR_CNT_W-1:0] err_cnt_out;

    modport master (
        output d0_p_in, d0_n_in, d1_p_in, d1_n_in,
        input  d_p_out, d_n_out, eval_out, pre_out, err_out, err_cnt_out
    );

    modport slave (
        input  d0_p_in, d0_n_in, d1_p_in, d1_n_in,
        output d_p_out, d_n_out, eval_out, pre_out, err_out, err_cnt_out
    );
endinterface

// File: rtl/wddl_xor2_8_reg.sv
// -----------------------------------------------------------------------------
// wddl_xor2_8_reg
// Registered WIDTH-bit dual-rail (WDDL) XOR for the AddRoundKey datapath.
// Each logical bit travels on a true rail (p) and a complement rail (n); the
// all-zero pair is the precharge spacer. The data path uses only AND/OR of
// positive rails so precharge propagates monotonically. Word-level status
// (evaluated / precharged), invalid-encoding detection and a saturating error
// counter are provided for side-channel and fault monitoring.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   wddl_xor2_8_reg_if.slave: operands in, registered results out
//
// Latency is one cycle with no handshake; a new operand may be applied every
// cycle.
// -----------------------------------------------------------------------------
module wddl_xor2_8_reg #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    wddl_xor2_8_reg_if.slave  bus
);

    logic [WIDTH-1:0] p_nxt;
    logic [WIDTH-1:0] n_nxt;
    logic [WIDTH-1:0] bad_bit;
    logic             eval_nxt;
    logic             pre_nxt;
    logic             err_nxt;

    // Per-bit WDDL XOR2 gate plus word-level status of the next-state result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        p_nxt    = '0;
        n_nxt    = '0;
        bad_bit  = '0;
        eval_nxt = 1'b0;
        pre_nxt  = 1'b0;
        err_nxt  = 1'b0;

        // A (1,1) pair on either operand is an illegal encoding; that bit is
        // squashed to the spacer so it never looks like a valid evaluation.
        bad_bit = (bus.d0_p_in & bus.d0_n_in) | (bus.d1_p_in & bus.d1_n_in);

        p_nxt = ((bus.d0_p_in & bus.d1_n_in) | (bus.d0_n_in & bus.d1_p_in)) & ~bad_bit;
        n_nxt = ((bus.d0_p_in & bus.d1_p_in) | (bus.d0_n_in & bus.d1_n_in)) & ~bad_bit;

        // Status is computed from the next-state result so it lines up with
        // the registered rails. Mixed words report neither evaluated nor
        // precharged; both can never be true since eval needs p^n on every bit.
        eval_nxt = &(p_nxt ^ n_nxt);
        pre_nxt  = ~|(p_nxt | n_nxt);
        err_nxt  = |bad_bit;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            // Reset wins over any input, including an illegal one this cycle.
            bus.d_p_out     <= '0;
            bus.d_n_out     <= '0;
            bus.eval_out    <= 1'b0;
            bus.pre_out     <= 1'b1;
            bus.err_out     <= 1'b0;
            bus.err_cnt_out <= '0;
        end else begin
            bus.d_p_out  <= p_nxt;
            bus.d_n_out  <= n_nxt;
            bus.eval_out <= eval_nxt;
            bus.pre_out  <= pre_nxt;
            bus.err_out  <= err_nxt;
            // Saturate at all-ones rather than wrapping back to a clean count.
            if (err_nxt && (bus.err_cnt_out != {ERR_CNT_W{1'b1}})) begin
                bus.err_cnt_out <= bus.err_cnt_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wddl_xor2_8_reg.sv
// -----------------------------------------------------------------------------
// tb_wddl_xor2_8_reg
// Directed self-checking bench for wddl_xor2_8_reg. Inputs are applied 1 ns
// after a rising edge and outputs are sampled 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_wddl_xor2_8_reg;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wddl_xor2_8_reg_if #(.WIDTH(8), .ERR_CNT_W(8)) bus ();

    wddl_xor2_8_reg #(.WIDTH(8), .ERR_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Apply operands, then advance one clock edge and settle.
    task automatic step(input logic [7:0] a_p, input logic [7:0] a_n,
                        input logic [7:0] b_p, input logic [7:0] b_n);
        bus.d0_p_in = a_p;
        bus.d0_n_in = a_n;
        bus.d1_p_in = b_p;
        bus.d1_n_in = b_n;
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [7:0] p,
                              input logic [7:0] n, input logic ev,
                              input logic pr, input logic er,
                              input logic [7:0] cnt);
        check({tag, ".p"},    32'(bus.d_p_out),     32'(p));
        check({tag, ".n"},    32'(bus.d_n_out),     32'(n));
        check({tag, ".eval"}, 32'(bus.eval_out),    32'(ev));
        check({tag, ".pre"},  32'(bus.pre_out),     32'(pr));
        check({tag, ".err"},  32'(bus.err_out),     32'(er));
        check({tag, ".cnt"},  32'(bus.err_cnt_out), 32'(cnt));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset for two cycles with random (possibly illegal) operands.
        rst = 1'b1;
        step(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        step(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        check_word("reset", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);

        // Basic evaluation: A5 ^ 3C = 99.
        rst = 1'b0;
        step(8'hA5, 8'h5A, 8'h3C, 8'hC3);
        check_word("eval", 8'h99, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00);

        // Precharge / evaluate alternation: FF ^ 0F = F0.
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 8'h00, 8'h00, 8'h00);
            check_word("alt_pre", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
            step(8'hFF, 8'h00, 8'h0F, 8'hF0);
            check_word("alt_eval", 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h00);
        end

        // Partial precharge: only bit0 of d1 evaluated (as 1) -> bit0 = (0,1).
        step(8'hFF, 8'h00, 8'h01, 8'h00);
        check_word("partial", 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00);

        // Invalid bit7 on d0; bits 6:0 are 05 ^ 0F = 0A.
        step(8'h85, 8'hFA, 8'h0F, 8'hF0);
        check_word("invalid", 8'h0A, 8'h75, 1'b0, 1'b0, 1'b1, 8'h01);

        // Error flag lasts only one cycle; count holds.
        step(8'hA5, 8'h5A, 8'h3C, 8'hC3);
        check_word("after_inv", 8'h99, 8'h66, 1'b1, 1'b0, 1'b0, 8'h01);

        // Saturation: count goes 1 -> FE after 253 illegal cycles, FF after 254,
        // then stays at FF for the remainder of 300 cycles.
        for (int i = 0; i < 253; i++) step(8'h85, 8'hFA, 8'h0F, 8'hF0);
        check("sat_fe", 32'(bus.err_cnt_out), 32'h0000_00FE);
        step(8'h85, 8'hFA, 8'h0F, 8'hF0);
        check("sat_ff", 32'(bus.err_cnt_out), 32'h0000_00FF);
        for (int i = 0; i < 46; i++) step(8'h85, 8'hFA, 8'h0F, 8'hF0);
        check_word("sat_hold", 8'h0A, 8'h75, 1'b0, 1'b0, 1'b1, 8'hFF);

        // Reset priority over an illegal input in the same cycle.
        rst = 1'b1;
        step(8'h85, 8'hFA, 8'h0F, 8'hF0);
        check_word("rst_prio", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);

        // First post-reset edge captures new operands normally.
        rst = 1'b0;
        step(8'hA5, 8'h5A, 8'h3C, 8'hC3);
        check_word("post_rst", 8'h99, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00);

        // Mid-stream reset discards the pending result.
        step(8'hFF, 8'h00, 8'h0F, 8'hF0);
        rst = 1'b1;
        step(8'hFF, 8'h00, 8'h0F, 8'hF0);
        check_word("mid_rst", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
